// File: rtl/mfu_seq_ctrl_if.sv
// Bundle of job, operand, mfu and result signals between the mfu job
// sequencer (slave) and the scheduler/mfu side of the datapath (master).
interface mfu_seq_ctrl_if #(
  parameter int LEN_W = 16
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic             cmd_sx;
  logic             cmd_sy;
  logic [LEN_W-1:0] cmd_len;
  logic             op_valid;
  logic             op_ready;
  logic [7:0]       op_x;
  logic [7:0]       op_y;
  logic [7:0]       mfu_x;
  logic [7:0]       mfu_y;
  logic             mfu_sx;
  logic             mfu_sy;
  logic [1:0]       mfu_mode;
  logic             mfu_en;
  logic [127:0]     mfu_sum;
  logic             res_valid;
  logic             res_ready;
  logic [127:0]     res_sum;
  logic [1:0]       res_mode;
  logic             busy;
  logic             err;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_sx, cmd_sy, cmd_len,
    input  op_valid, op_x, op_y, mfu_sum, res_ready,
    output cmd_ready, op_ready, mfu_x, mfu_y, mfu_sx, mfu_sy, mfu_mode, mfu_en,
    output res_valid, res_sum, res_mode, busy, err
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_sx, cmd_sy, cmd_len,
    output op_valid, op_x, op_y, mfu_sum, res_ready,
    input  cmd_ready, op_ready, mfu_x, mfu_y, mfu_sx, mfu_sy, mfu_mode, mfu_en,
    input  res_valid, res_sum, res_mode, busy, err
  );
endinterface

// File: rtl/mfu_seq_ctrl.sv
// Job sequencer for one mfu MAC: clears the accumulator, streams the job's
// operand beats into the mfu and returns the captured sum on a handshake.
//
// state  | meaning
// IDLE   | waiting for a job descriptor; illegal mode is rejected with err
// CLR    | mfu_mode forced to 11 so the mfu sum clears
// SETTLE | job mode applied to the mfu (mode change clears the sum again)
// STREAM | operand pairs passed through, one mfu_en per accepted beat
// WAIT   | last beat has landed in mfu_sum; capture it
// DONE   | result held on res_* until res_ready
module mfu_seq_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  mfu_seq_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]       state;
  logic [1:0]       job_mode;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_inc;
  logic [1:0]       mfu_mode_q;
  logic             mfu_sx_q;
  logic             mfu_sy_q;
  logic [127:0]     res_sum_q;
  logic [1:0]       res_mode_q;
  logic             err_q;
  logic             streaming;
  logic             beat;

  assign streaming = (state == S_STREAM);
  assign beat      = streaming & bus.op_valid;
  assign cnt_inc   = cnt + LEN_W'(1);

  // Sequencer state, job latches, mfu control registers and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      job_mode   <= 2'b00;
      len_q      <= '0;
      cnt        <= '0;
      mfu_mode_q <= 2'b11;
      mfu_sx_q   <= 1'b0;
      mfu_sy_q   <= 1'b0;
      res_sum_q  <= '0;
      res_mode_q <= 2'b00;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_mode == 2'b11) begin
              err_q <= 1'b1;
            end else begin
              job_mode   <= bus.cmd_mode;
              len_q      <= bus.cmd_len;
              mfu_sx_q   <= bus.cmd_sx;
              mfu_sy_q   <= bus.cmd_sy;
              cnt        <= '0;
              mfu_mode_q <= 2'b11;
              state      <= S_CLR;
            end
          end
        end
        S_CLR: begin
          mfu_mode_q <= job_mode;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          state <= (len_q == '0) ? S_WAIT : S_STREAM;
        end
        S_STREAM: begin
          if (beat) begin
            cnt <= cnt_inc;
            if (cnt_inc == len_q) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          res_sum_q  <= bus.mfu_sum;
          res_mode_q <= job_mode;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (bus.res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.op_ready  = streaming;
  assign bus.mfu_en    = beat;
  assign bus.mfu_x     = streaming ? bus.op_x : 8'h00;
  assign bus.mfu_y     = streaming ? bus.op_y : 8'h00;
  assign bus.mfu_mode  = mfu_mode_q;
  assign bus.mfu_sx    = mfu_sx_q;
  assign bus.mfu_sy    = mfu_sy_q;
  assign bus.res_valid = (state == S_DONE);
  assign bus.res_sum   = res_sum_q;
  assign bus.res_mode  = res_mode_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mfu_seq_ctrl.sv
// Directed bench for mfu_seq_ctrl with a behavioural mfu (outer-product
// lanes: 2b -> 16 x 8-bit, 4b -> 4 x 12-bit, 8b -> 1 x 20-bit).
module tb_mfu_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mfu_seq_ctrl_if #(.LEN_W(16)) bus ();

  mfu_seq_ctrl #(.LEN_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural mfu: clears on mode 11 or a mode change, accumulates on en.
  logic [127:0] mfu_acc   = '0;
  logic [1:0]   prev_mode = 2'b11;

  function automatic logic [127:0] mfu_next(input logic [127:0] acc, input logic [1:0] mode,
                                            input logic sx, input logic sy,
                                            input logic [7:0] x, input logic [7:0] y);
    logic [127:0] r;
    int bw, lw, n, xe, ye, lv, lane;
    r = acc;
    case (mode)
      2'b00:   begin bw = 2; lw = 8;  end
      2'b01:   begin bw = 4; lw = 12; end
      default: begin bw = 8; lw = 20; end
    endcase
    n = 8 / bw;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        xe = 0;
        ye = 0;
        for (int b = 0; b < bw; b++) begin
          if (x[i*bw+b]) xe = xe | (1 << b);
          if (y[j*bw+b]) ye = ye | (1 << b);
        end
        if (sx && x[i*bw+bw-1]) xe = xe - (1 << bw);
        if (sy && y[j*bw+bw-1]) ye = ye - (1 << bw);
        lane = i * n + j;
        lv = 0;
        for (int b = 0; b < lw; b++) if (r[lane*lw+b]) lv = lv | (1 << b);
        lv = lv + xe * ye;
        for (int b = 0; b < lw; b++) r[lane*lw+b] = lv[b];
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    prev_mode <= bus.mfu_mode;
    if (bus.mfu_mode == 2'b11 || bus.mfu_mode != prev_mode) mfu_acc <= '0;
    else if (bus.mfu_en) mfu_acc <= mfu_next(mfu_acc, bus.mfu_mode, bus.mfu_sx, bus.mfu_sy,
                                             bus.mfu_x, bus.mfu_y);
  end
  assign bus.mfu_sum = mfu_acc;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one job from IDLE through the result handshake, returning timing/observations.
  task automatic run_job(input logic [1:0] mode, input logic sx, input logic sy,
                         input logic [15:0] len, input logic [7:0] x, input logic [7:0] y,
                         input logic gap, input int hold,
                         output int res_cyc, output int en_cnt, output int rdy_cnt,
                         output logic [127:0] sum, output logic [1:0] rmode, output logic held_ok);
    int cyc;
    res_cyc = -1;
    en_cnt  = 0;
    rdy_cnt = 0;
    held_ok = 1'b1;
    bus.cmd_mode  = mode;
    bus.cmd_sx    = sx;
    bus.cmd_sy    = sy;
    bus.cmd_len   = len;
    bus.op_x      = x;
    bus.op_y      = y;
    bus.op_valid  = 1'b0;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    cyc = 1;
    while (cyc <= 60) begin
      if (bus.op_ready) rdy_cnt++;
      bus.op_valid = bus.op_ready && (!gap || (rdy_cnt % 2 == 1));
      #1;
      if (bus.mfu_en) en_cnt++;
      if (bus.res_valid) begin
        res_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.op_valid = 1'b0;
    sum   = bus.res_sum;
    rmode = bus.res_mode;
    repeat (hold) begin
      @(posedge clk); #1;
      if (bus.res_sum !== sum || bus.cmd_ready !== 1'b0 || bus.res_valid !== 1'b1) held_ok = 1'b0;
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  int           rc, ec, qc;
  logic [127:0] s;
  logic [1:0]   m;
  logic         h;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_mode  = 2'b00;
    bus.cmd_sx    = 1'b0;
    bus.cmd_sy    = 1'b0;
    bus.cmd_len   = '0;
    bus.op_valid  = 1'b0;
    bus.op_x      = '0;
    bus.op_y      = '0;
    bus.res_ready = 1'b0;
    #12;
    check("rst_busy",      128'(bus.busy),      128'd0);
    check("rst_res_valid", 128'(bus.res_valid), 128'd0);
    check("rst_mfu_mode",  128'(bus.mfu_mode),  128'd3);
    check("rst_err",       128'(bus.err),       128'd0);
    check("rst_res_sum",   bus.res_sum,         128'd0);
    check("rst_cmd_ready", 128'(bus.cmd_ready), 128'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 8b signed, -3 * 5 over 4 beats
    run_job(2'b10, 1'b1, 1'b1, 16'd4, 8'hFD, 8'h05, 1'b0, 0, rc, ec, qc, s, m, h);
    check("j1_res_cyc",  128'(rc), 128'd8);
    check("j1_en_cnt",   128'(ec), 128'd4);
    check("j1_sum_lo",   128'(s[19:0]), 128'hFFFC4);
    check("j1_sum_hi",   s >> 20, 128'd0);
    check("j1_res_mode", 128'(m), 128'd2);

    // 4b unsigned, twice back-to-back
    run_job(2'b01, 1'b0, 1'b0, 16'd3, 8'h11, 8'h11, 1'b0, 0, rc, ec, qc, s, m, h);
    check("j2a_sum",     s, 128'h003003003003);
    check("j2a_res_cyc", 128'(rc), 128'd7);
    run_job(2'b01, 1'b0, 1'b0, 16'd3, 8'h11, 8'h11, 1'b0, 0, rc, ec, qc, s, m, h);
    check("j2b_sum",     s, 128'h003003003003);
    check("j2b_res_mode", 128'(m), 128'd1);

    // 2b signed with a one-cycle op_valid gap, result held 5 cycles
    run_job(2'b00, 1'b1, 1'b1, 16'd2, 8'hFF, 8'hFF, 1'b1, 5, rc, ec, qc, s, m, h);
    check("j3_en_cnt",  128'(ec), 128'd2);
    check("j3_sum",     s, {16{8'h02}});
    check("j3_held",    128'(h), 128'd1);
    check("j3_res_cyc", 128'(rc), 128'd7);
    check("j3_rdy_cnt", 128'(qc), 128'd3);

    // Zero-length job
    run_job(2'b01, 1'b0, 1'b0, 16'd0, 8'h55, 8'h33, 1'b0, 0, rc, ec, qc, s, m, h);
    check("j4_res_cyc", 128'(rc), 128'd4);
    check("j4_sum",     s, 128'd0);
    check("j4_rdy_cnt", 128'(qc), 128'd0);

    // Illegal mode: one-cycle err, no state change
    bus.cmd_mode  = 2'b11;
    bus.cmd_len   = 16'd7;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("ill_err",       128'(bus.err),       128'd1);
    check("ill_busy",      128'(bus.busy),      128'd0);
    check("ill_mfu_mode",  128'(bus.mfu_mode),  128'd1);
    check("ill_cmd_ready", 128'(bus.cmd_ready), 128'd1);
    @(posedge clk); #1;
    check("ill_err_clear", 128'(bus.err),       128'd0);
    check("ill_busy2",     128'(bus.busy),      128'd0);

    // Reset during STREAM after 2 of 5 beats
    bus.cmd_mode  = 2'b10;
    bus.cmd_sx    = 1'b0;
    bus.cmd_sy    = 1'b0;
    bus.cmd_len   = 16'd5;
    bus.op_x      = 8'h07;
    bus.op_y      = 8'h09;
    bus.op_valid  = 1'b1;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("abort_pre_busy", 128'(bus.busy), 128'd1);
    rst = 1'b1;
    #1;
    check("abort_busy",      128'(bus.busy),      128'd0);
    check("abort_res_valid", 128'(bus.res_valid), 128'd0);
    check("abort_mfu_mode",  128'(bus.mfu_mode),  128'd3);
    check("abort_err",       128'(bus.err),       128'd0);
    bus.op_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_job(2'b10, 1'b0, 1'b0, 16'd1, 8'h02, 8'h03, 1'b0, 0, rc, ec, qc, s, m, h);
    check("post_sum",     s, 128'd6);
    check("post_res_cyc", 128'(rc), 128'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
